// File: rtl/div_recombiner_if.sv
// Operand/result bundle for div_recombiner; master drives operands and start,
// slave returns the reconstructed dividend and status flags.
interface div_recombiner_if #(
    parameter int divisorBITS  = 10,
    parameter int dividendBITS = 20
) ();
    logic                    start;
    logic [divisorBITS-1:0]  divisor;
    logic [dividendBITS-1:0] quotient;
    logic [divisorBITS-1:0]  remainder;
    logic                    busy;
    logic                    done;
    logic [dividendBITS-1:0] dividend;
    logic                    ovf;
    logic                    rem_err;

    modport master (
        output start, divisor, quotient, remainder,
        input  busy, done, dividend, ovf, rem_err
    );

    modport slave (
        input  start, divisor, quotient, remainder,
        output busy, done, dividend, ovf, rem_err
    );
endinterface

// File: rtl/div_recombiner.sv
// Serial shift-add reconstruction: dividend = quotient*divisor + remainder.
// Define DIV_RECOMBINER_CHECK_EN to enable the remainder >= divisor check.
module div_recombiner #(
    parameter int divisorBITS  = 10,
    parameter int dividendBITS = 20
) (
    input logic            clk,
    input logic            rst_n,
    div_recombiner_if.slave bus
);
    localparam int W  = divisorBITS + dividendBITS;
    localparam int CW = $clog2(dividendBITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                  state;
    logic [W-1:0]            acc;
    logic [CW-1:0]           cnt;
    logic [divisorBITS-1:0]  div_r;
    logic [divisorBITS-1:0]  rem_r;
    logic [dividendBITS-1:0] quo_r;
    logic                    busy;
    logic                    done;
    logic [dividendBITS-1:0] dividend;
    logic                    ovf;
    logic [W:0]              sum;
    logic [W-1:0]            addend;

    // One extra bit keeps the final carry visible to ovf.
    assign sum    = {1'b0, acc} + {{(W + 1 - divisorBITS){1'b0}}, rem_r};
    assign addend = quo_r[dividendBITS-1] ? {{dividendBITS{1'b0}}, div_r} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            div_r    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dividend <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        div_r <= bus.divisor;
                        rem_r <= bus.remainder;
                        quo_r <= bus.quotient;
                        acc   <= '0;
                        cnt   <= CW'(dividendBITS);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= (acc << 1) + addend;
                    quo_r <= quo_r << 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIN;
                end
                FIN: begin
                    dividend <= sum[dividendBITS-1:0];
                    ovf      <= |sum[W:dividendBITS];
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIV_RECOMBINER_CHECK_EN
    logic rem_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rem_err <= 1'b0;
        else if (state == FIN)
            rem_err <= (rem_r >= div_r);
    end

    assign bus.rem_err = rem_err;
`else
    assign bus.rem_err = 1'b0;
`endif

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.dividend = dividend;
    assign bus.ovf      = ovf;
endmodule
